// File: rtl/tlul_pkg.sv
// ============================================================================
//  Module      : tlul_pkg
//  Description : TL-UL host/device channel types and integrity helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    localparam logic [3:0] InstrTypeDefault = 4'h9;

    typedef struct packed {
        logic [4:0] rsvd;
        logic [3:0] instr_type;
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        tl_d_user_t  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    // 7-bit check code: XOR fold of the padded payload in 7-bit slices.
    function automatic logic [6:0] intg_fold(input logic [56:0] d);
        logic [62:0] p;
        p = {6'b0, d};
        return p[6:0] ^ p[13:7] ^ p[20:14] ^ p[27:21] ^ p[34:28]
             ^ p[41:35] ^ p[48:42] ^ p[55:49] ^ p[62:56];
    endfunction

    function automatic logic [6:0] get_cmd_intg(input tl_h2d_t tl);
        return intg_fold({14'b0, tl.a_user.instr_type, tl.a_address, tl.a_opcode, tl.a_mask});
    endfunction

    function automatic logic [6:0] get_data_intg(input logic [31:0] data);
        return intg_fold({25'b0, data});
    endfunction

endpackage

`default_nettype wire

// File: rtl/tlul_stream_host_pkg.sv
// ============================================================================
//  Module      : tlul_stream_host_pkg
//  Description : States, command and status codes of the byte-stream TL-UL host.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tlul_stream_host_pkg;

    typedef enum logic [2:0] {
        CMD       = 3'd0,
        ADDR      = 3'd1,
        WDATA     = 3'd2,
        REQ       = 3'd3,
        RSP       = 3'd4,
        TX_STATUS = 3'd5,
        TX_RDATA  = 3'd6
    } state_e;

    localparam logic [7:0] CmdRead      = 8'h01;
    localparam logic [7:0] CmdWrite     = 8'h02;

    localparam logic [7:0] StatusOk     = 8'h00;
    localparam logic [7:0] StatusErr    = 8'h01;
    localparam logic [7:0] StatusBadCmd = 8'h02;

endpackage

`default_nettype wire

// File: rtl/tlul_cmd_intg_gen.sv
// ============================================================================
//  Module      : tlul_cmd_intg_gen
//  Description : Fills in A-channel command and data integrity fields.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlul_cmd_intg_gen (
    input  tlul_pkg::tl_h2d_t tl_i,
    output tlul_pkg::tl_h2d_t tl_o
);

    always_comb begin
        tl_o                  = tl_i;
        tl_o.a_user.cmd_intg  = tlul_pkg::get_cmd_intg(tl_i);
        tl_o.a_user.data_intg = tlul_pkg::get_data_intg(tl_i.a_data);
    end

endmodule

`default_nettype wire

// File: rtl/tlul_stream_host.sv
// ============================================================================
//  Module      : tlul_stream_host
//  Description : Byte-stream command parser issuing single TL-UL reads/writes.
//                Optional inter-byte timeout: TLUL_STREAM_HOST_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlul_stream_host
    import tlul_stream_host_pkg::*;
#(
    parameter logic [7:0]  SourceId      = 8'd0,
    parameter int unsigned TimeoutCycles = 32'd1_250_000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output tlul_pkg::tl_h2d_t tl_o,
    input  tlul_pkg::tl_d2h_t tl_i,
    output logic              busy_o
);

    state_e            r_state, w_state_next;
    logic [1:0]        r_cnt;
    logic              r_is_write;
    logic [31:0]       r_addr, r_wdata, r_rdata;
    logic [7:0]        r_status;
    logic              w_in_frame, w_timeout, w_cmd_ok;
    tlul_pkg::tl_h2d_t w_tl_raw;

    assign w_in_frame = (r_state == ADDR) || (r_state == WDATA);
    assign w_cmd_ok   = (rx_data_i == CmdRead) || (rx_data_i == CmdWrite);
    assign busy_o     = (r_state != CMD);

`ifdef TLUL_STREAM_HOST_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TimeoutCycles + 1);
    logic [TMO_W-1:0] r_tmo;

    // Counts idle cycles between frame bytes; any accepted byte restarts it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tmo <= '0;
        end else if (w_in_frame && !rx_valid_i) begin
            r_tmo <= r_tmo + 1'b1;
        end else begin
            r_tmo <= '0;
        end
    end

    assign w_timeout = w_in_frame && !rx_valid_i && (r_tmo == TMO_W'(TimeoutCycles - 1));
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TimeoutCycles == 32'd0);
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= CMD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // In CMD/ADDR/WDATA rx_ready is high and in TX_* tx_valid is high, so the
    // raw valid/ready inputs stand for the handshakes below.
    always_comb begin
        w_state_next = r_state;
        rx_ready_o   = 1'b0;
        tx_valid_o   = 1'b0;
        tx_data_o    = 8'h00;
        unique case (r_state)
            CMD: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i) w_state_next = w_cmd_ok ? ADDR : TX_STATUS;
            end
            ADDR: begin
                rx_ready_o = 1'b1;
                if (w_timeout) w_state_next = CMD;
                else if (rx_valid_i && r_cnt == 2'd3) w_state_next = r_is_write ? WDATA : REQ;
            end
            WDATA: begin
                rx_ready_o = 1'b1;
                if (w_timeout) w_state_next = CMD;
                else if (rx_valid_i && r_cnt == 2'd3) w_state_next = REQ;
            end
            REQ: if (tl_i.a_ready) w_state_next = RSP;
            RSP: if (tl_i.d_valid) w_state_next = TX_STATUS;
            TX_STATUS: begin
                tx_valid_o = 1'b1;
                tx_data_o  = r_status;
                if (tx_ready_i) w_state_next = (!r_is_write && r_status == StatusOk) ? TX_RDATA : CMD;
            end
            TX_RDATA: begin
                tx_valid_o = 1'b1;
                tx_data_o  = r_rdata[{r_cnt, 3'b000} +: 8];
                if (tx_ready_i && r_cnt == 2'd3) w_state_next = CMD;
            end
            default: w_state_next = CMD;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt      <= 2'd0;
            r_is_write <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_rdata    <= 32'h0;
            r_status   <= 8'h00;
        end else begin
            unique case (r_state)
                CMD: if (rx_valid_i) begin
                    r_cnt      <= 2'd0;
                    r_is_write <= (rx_data_i == CmdWrite);
                    if (!w_cmd_ok) r_status <= StatusBadCmd;
                end
                ADDR: if (rx_valid_i) begin
                    r_addr[{r_cnt, 3'b000} +: 8] <= rx_data_i;
                    r_cnt                        <= r_cnt + 2'd1;
                end
                WDATA: if (rx_valid_i) begin
                    r_wdata[{r_cnt, 3'b000} +: 8] <= rx_data_i;
                    r_cnt                         <= r_cnt + 2'd1;
                end
                RSP: if (tl_i.d_valid) begin
                    r_rdata  <= tl_i.d_data;
                    r_status <= tl_i.d_error ? StatusErr : StatusOk;
                end
                TX_STATUS: if (tx_ready_i) r_cnt <= 2'd0;
                TX_RDATA:  if (tx_ready_i) r_cnt <= r_cnt + 2'd1;
                default: ;
            endcase
        end
    end

    // A fields come straight from registers that only move outside REQ.
    always_comb begin
        w_tl_raw                   = '0;
        w_tl_raw.a_valid           = (r_state == REQ);
        w_tl_raw.a_opcode          = r_is_write ? tlul_pkg::PutFullData : tlul_pkg::Get;
        w_tl_raw.a_param           = 3'd0;
        w_tl_raw.a_size            = 2'd2;
        w_tl_raw.a_source          = SourceId;
        w_tl_raw.a_address         = {r_addr[31:2], 2'b00};
        w_tl_raw.a_mask            = 4'hF;
        w_tl_raw.a_data            = r_is_write ? r_wdata : 32'h0;
        w_tl_raw.a_user.instr_type = tlul_pkg::InstrTypeDefault;
        w_tl_raw.d_ready           = (r_state == CMD) || (r_state == RSP);
    end

    tlul_cmd_intg_gen u_intg_gen (
        .tl_i (w_tl_raw),
        .tl_o (tl_o)
    );

    logic w_unused_tl;
    assign w_unused_tl = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size,
                           tl_i.d_source, tl_i.d_sink, tl_i.d_user};

endmodule

`default_nettype wire

// File: tb/tb_tlul_stream_host.sv
// ============================================================================
//  Module      : tb_tlul_stream_host
//  Description : Self-checking bench for tlul_stream_host (vector table + scoreboard).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tlul_stream_host;
    import tlul_stream_host_pkg::*;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [7:0]        rx_data_i = 8'h00;
    logic              rx_valid_i = 1'b0;
    logic              rx_ready_o;
    logic [7:0]        tx_data_o;
    logic              tx_valid_o;
    logic              tx_ready_i = 1'b1;
    tlul_pkg::tl_h2d_t tl_o;
    tlul_pkg::tl_d2h_t tl_i;
    logic              busy_o;

    always #5 clk_i = ~clk_i;

    tlul_stream_host #(.SourceId(8'h5A), .TimeoutCycles(16)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .tl_o       (tl_o),
        .tl_i       (tl_i),
        .busy_o     (busy_o)
    );

    typedef struct packed {
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        derr;
        logic [4:0]  dly;
        logic        tog;
        logic        has_tl;
        logic [31:0] exp_addr;
        logic [7:0]  exp_status;
    } vec_t;

    typedef struct packed {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        derr;
        logic [4:0]  delay;
    } tl_exp_t;

    vec_t       vecs[9];
    logic [7:0] tx_q[$];
    tl_exp_t    tl_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_tl     = 0;
    logic       tx_toggle = 1'b0;
    logic       d_hold    = 1'b0;
    logic       drain     = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic derr, input logic [4:0] dly,
                                input logic tog, input logic has_tl, input logic [31:0] exp_addr,
                                input logic [7:0] exp_status);
        vec_t v;
        v.cmd = cmd; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.derr = derr;
        v.dly = dly; v.tog = tog; v.has_tl = has_tl; v.exp_addr = exp_addr; v.exp_status = exp_status;
        return v;
    endfunction

    // TL-UL device: checks each A request against the scoreboard, then answers.
    initial begin : device
        tl_exp_t           e;
        tlul_pkg::tl_h2d_t snap;
        logic              stable, single;
        int                n;
        tl_i = '0;
        forever begin
            @(negedge clk_i);
            if (tl_o.a_valid) begin
                if (tl_q.size() == 0) begin
                    check("tl_unexpected_request", {32'h0, tl_o.a_address}, 64'hFFFF_FFFF_FFFF_FFFF);
                    e = '0;
                end else begin
                    e = tl_q.pop_front();
                end
                check("a_opcode", 64'(tl_o.a_opcode), e.is_wr ? 64'(tlul_pkg::PutFullData) : 64'(tlul_pkg::Get));
                check("a_address", 64'(tl_o.a_address), 64'(e.addr));
                check("a_size", 64'(tl_o.a_size), 64'd2);
                check("a_mask", 64'(tl_o.a_mask), 64'hF);
                check("a_source", 64'(tl_o.a_source), 64'h5A);
                check("a_param", 64'(tl_o.a_param), 64'd0);
                if (e.is_wr) check("a_data", 64'(tl_o.a_data), 64'(e.wdata));
                snap   = tl_o;
                stable = 1'b1;
                for (int i = 0; i < int'(e.delay); i++) begin
                    @(negedge clk_i);
                    if (tl_o !== snap) stable = 1'b0;
                end
                if (e.delay != 0) check("a_stable_while_stalled", 64'(stable), 64'd1);
                tl_i.a_ready = 1'b1;
                @(negedge clk_i);
                tl_i.a_ready = 1'b0;
                n_tl++;
                while (d_hold) @(negedge clk_i);
                tl_i.d_valid  = 1'b1;
                tl_i.d_data   = e.rdata;
                tl_i.d_error  = e.derr;
                tl_i.d_opcode = e.is_wr ? tlul_pkg::AccessAck : tlul_pkg::AccessAckData;
                n = 0;
                single = 1'b1;
                while (!tl_o.d_ready && n < 200) begin
                    if (tl_o.a_valid) single = 1'b0;
                    @(negedge clk_i);
                    n++;
                end
                check("d_ready_timeout", 64'(n >= 200), 64'd0);
                check("single_outstanding", 64'(single), 64'd1);
                @(negedge clk_i);
                if (!drain) check("status_latency", 64'(tx_valid_o), 64'd1);
                tl_i.d_valid = 1'b0;
                tl_i.d_error = 1'b0;
            end
        end
    end

    // Response sink: optional ready toggling, hold-stability and byte scoreboard.
    initial begin : tx_sink
        logic [7:0] prev;
        logic       pend;
        pend = 1'b0;
        prev = 8'h00;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                pend = 1'b0;
            end else begin
                tx_ready_i = tx_toggle ? ~tx_ready_i : 1'b1;
                if (pend) check("tx_hold", {55'h0, tx_valid_o, tx_data_o}, {55'h0, 1'b1, prev});
                if (tx_valid_o && tx_ready_i) begin
                    if (tx_q.size() == 0) check("tx_unexpected_byte", 64'(tx_data_o), 64'h100);
                    else check("tx_byte", 64'(tx_data_o), 64'(tx_q.pop_front()));
                    pend = 1'b0;
                end else begin
                    pend = tx_valid_o;
                end
                prev = tx_data_o;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n          = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        while (!rx_ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("rx_accept_timeout", 64'(n >= 100), 64'd0);
        @(negedge clk_i);
        rx_valid_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        tl_exp_t e;
        int      n, tl0;
        logic    wr;
        wr        = (v.cmd == CmdWrite);
        tx_toggle = v.tog;
        tl0       = n_tl;
        tx_q.push_back(v.exp_status);
        if (v.has_tl) begin
            e.is_wr = wr; e.addr = v.exp_addr; e.wdata = v.wdata;
            e.rdata = v.rdata; e.derr = v.derr; e.delay = v.dly;
            tl_q.push_back(e);
            if (!wr && v.exp_status == StatusOk)
                for (int i = 0; i < 4; i++) tx_q.push_back(v.rdata[8*i +: 8]);
        end
        send_byte(v.cmd);
        if (v.has_tl) begin
            for (int i = 0; i < 4; i++) send_byte(v.addr[8*i +: 8]);
            if (wr) for (int i = 0; i < 4; i++) send_byte(v.wdata[8*i +: 8]);
            check("a_valid_latency", 64'(tl_o.a_valid), 64'd1);
        end
        n = 0;
        while ((tx_q.size() != 0 || busy_o) && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        check("frame_timeout", 64'(n >= 400), 64'd0);
        check("busy_idle", 64'(busy_o), 64'd0);
        check("tl_count", 64'(n_tl - tl0), 64'(v.has_tl));
    endtask

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        tl_exp_t e;
        int      n, tl0;

        vecs[0] = mk(8'h02, 32'h0001_0000, 32'hDEAD_BEEF, 32'h0,         1'b0, 5'd0,  1'b0, 1'b1, 32'h0001_0000, 8'h00);
        vecs[1] = mk(8'h01, 32'h0001_0000, 32'h0,         32'hDEAD_BEEF, 1'b0, 5'd0,  1'b0, 1'b1, 32'h0001_0000, 8'h00);
        vecs[2] = mk(8'h7F, 32'h0,         32'h0,         32'h0,         1'b0, 5'd0,  1'b0, 1'b0, 32'h0,         8'h02);
        vecs[3] = mk(8'h01, 32'h7654_3213, 32'h0,         32'h1234_5678, 1'b1, 5'd0,  1'b0, 1'b1, 32'h7654_3210, 8'h01);
        vecs[4] = mk(8'h01, 32'h8000_0004, 32'h0,         32'hA5C3_1E0F, 1'b0, 5'd3,  1'b1, 1'b1, 32'h8000_0004, 8'h00);
        vecs[5] = mk(8'h02, 32'hFFFF_FFFF, 32'h4433_2211, 32'h0,         1'b0, 5'd20, 1'b1, 1'b1, 32'hFFFF_FFFC, 8'h00);
        vecs[6] = mk(8'h02, 32'h0000_0008, 32'h0000_0001, 32'h0,         1'b1, 5'd1,  1'b0, 1'b1, 32'h0000_0008, 8'h01);
        vecs[7] = mk(8'h00, 32'h0,         32'h0,         32'h0,         1'b0, 5'd0,  1'b0, 1'b0, 32'h0,         8'h02);
        vecs[8] = mk(8'h01, 32'h0000_00A0, 32'h0,         32'h0BAD_F00D, 1'b0, 5'd0,  1'b1, 1'b1, 32'h0000_00A0, 8'h00);

        repeat (3) @(negedge clk_i);
        check("rst_rx_ready", 64'(rx_ready_o), 64'd1);
        check("rst_tx_valid", 64'(tx_valid_o), 64'd0);
        check("rst_tx_data", 64'(tx_data_o), 64'h00);
        check("rst_a_valid", 64'(tl_o.a_valid), 64'd0);
        check("rst_d_ready", 64'(tl_o.d_ready), 64'd1);
        check("rst_busy", 64'(busy_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        for (int k = 0; k < 9; k++) run_vec(vecs[k]);

        // Reset while the read is waiting for its D response.
        tx_toggle = 1'b0;
        d_hold    = 1'b1;
        tl0       = n_tl;
        e.is_wr = 1'b0; e.addr = 32'h0000_0100; e.wdata = 32'h0;
        e.rdata = 32'hCAFE_F00D; e.derr = 1'b0; e.delay = 5'd0;
        tl_q.push_back(e);
        send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        n = 0;
        while (n_tl == tl0 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("rsp_wait_timeout", 64'(n >= 100), 64'd0);
        check("busy_in_rsp", 64'(busy_o), 64'd1);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        check("abort_busy", 64'(busy_o), 64'd0);
        check("abort_tx_valid", 64'(tx_valid_o), 64'd0);
        drain  = 1'b1;
        d_hold = 1'b0;
        repeat (10) @(negedge clk_i);
        check("late_rsp_drained", 64'(tl_i.d_valid), 64'd0);
        check("drain_no_tx", 64'(tx_valid_o), 64'd0);
        check("drain_busy", 64'(busy_o), 64'd0);
        drain = 1'b0;
        run_vec(vecs[1]);

`ifdef TLUL_STREAM_HOST_TIMEOUT_EN
        tl0 = n_tl;
        send_byte(8'h01);
        send_byte(8'h00);
        repeat (18) @(negedge clk_i);
        check("timeout_busy", 64'(busy_o), 64'd0);
        check("timeout_no_tl", 64'(n_tl - tl0), 64'd0);
        check("timeout_no_tx", 64'(tx_valid_o), 64'd0);
        run_vec(vecs[8]);
`endif

        repeat (5) @(negedge clk_i);
        check("tl_scoreboard_empty", 64'(tl_q.size()), 64'd0);
        check("tx_scoreboard_empty", 64'(tx_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tlul_stream_host.md
TLUL_STREAM_HOST -- requirements
Module: tlul_stream_host

Interface
REQ-001 Parameters SHALL be:
- SourceId, default 0, a_source value.
- TimeoutCycles, default 1_250_000, maximum idle cycles allowed between bytes of one frame.
REQ-002 Ports SHALL be:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- rx_data_i  in  8  command byte
- rx_valid_i  in  1  command byte valid
- rx_ready_o  out  1  command byte accepted
- tx_data_o  out  8  response byte
- tx_valid_o  out  1  response byte valid
- tx_ready_i  in  1  response sink ready
- tl_o  out  tlul_pkg::tl_h2d_t  TL-UL host request
- tl_i  in  tlul_pkg::tl_d2h_t  TL-UL device response
- busy_o  out  1  high whenever state is not CMD

Function
REQ-003 Both streams SHALL use a valid/ready handshake: a byte transfers on a cycle where valid and ready are both high; tx_data_o and tx_valid_o SHALL hold stable until accepted.
REQ-004 The frame format SHALL be:
- command byte: 0x01 = read, 0x02 = write.
- 4 address bytes, little-endian.
- for writes only, 4 data bytes, little-endian.
REQ-005 The FSM states SHALL be CMD, ADDR, WDATA, REQ, RSP, TX_STATUS, TX_RDATA; a 2-bit byte counter SHALL index the ADDR, WDATA and TX_RDATA bytes.
REQ-006 rx_ready_o SHALL be high only in CMD, ADDR and WDATA.
REQ-007 In CMD, an accepted byte of 0x01 or 0x02 SHALL go to ADDR; any other byte SHALL set status 0x02 and go to TX_STATUS with no TL transaction.
REQ-008 ADDR SHALL go to WDATA (write) or REQ (read) after the 4th byte; WDATA SHALL go to REQ after its 4th byte.
REQ-009 In REQ, a_valid SHALL be high and all A fields SHALL be stable until the cycle a_ready is high; the FSM SHALL then go to RSP.
REQ-010 A-channel fields SHALL be:
- a_opcode = Get (read) or PutFullData (write).
- a_size = 2, a_mask = 4'hF.
- a_address = captured address with bits [1:0] forced to 0.
- a_source = SourceId, a_param = 0.
- a_user integrity generated per tlul_pkg.
REQ-011 d_ready SHALL be high in RSP and in CMD; responses arriving in CMD SHALL be discarded.
REQ-012 In RSP, on d_valid the block SHALL capture d_data and set status to 0x01 if d_error is high, else 0x00, then go to TX_STATUS.
REQ-013 After the status byte is accepted, the FSM SHALL go to TX_RDATA only for a read with status 0x00; in all other cases it SHALL go to CMD.
REQ-014 TX_RDATA SHALL send 4 data bytes, LSB first, then go to CMD.
REQ-015 Minimum latency SHALL be: A request valid one cycle after the last frame byte is accepted; status byte valid one cycle after the d_valid handshake.
REQ-016 At most one TL transaction SHALL be outstanding at any time.

Reset
REQ-017 While rst_i is high at a clock edge, all state SHALL reset as follows:
- FSM to CMD, counters and data registers to 0.
- rx_ready_o = 1, tx_valid_o = 0, tx_data_o = 0x00, a_valid = 0, d_ready = 1, busy_o = 0.
REQ-018 A reset mid-frame or mid-transaction SHALL abort it with no response byte; a late D response SHALL be drained in CMD.

Configuration
REQ-019 With TLUL_STREAM_HOST_TIMEOUT_EN defined:
- a counter SHALL run in ADDR and WDATA and clear on every accepted byte.
- on reaching TimeoutCycles, the FSM SHALL return to CMD with no response byte and no TL transaction.
REQ-020 With TLUL_STREAM_HOST_TIMEOUT_EN undefined, no counter SHALL exist and ADDR/WDATA SHALL wait indefinitely.

Structure
REQ-021 A package tlul_stream_host_pkg SHALL hold:
- the state enum.
- command constants CmdRead = 0x01, CmdWrite = 0x02.
- status constants StatusOk = 0x00, StatusErr = 0x01, StatusBadCmd = 0x02.
REQ-022 The design SHALL be a single module; A-channel integrity SHALL reuse the existing tlul_cmd_intg_gen and no new sub-module SHALL be created.

Verification
REQ-023 Write 02 00 00 01 00 EF BE AD DE -> one PutFullData to address 0x00010000, data 0xDEADBEEF, mask 0xF; response byte 00.
REQ-024 Read 01 00 00 01 00, with the device returning 0xDEADBEEF -> one Get; response bytes 00 EF BE AD DE.
REQ-025 Command byte 0x7F -> response byte 02, no a_valid, next frame parsed normally.
REQ-026 Read with d_error = 1 -> response byte 01 only; tx_ready_i toggling every cycle -> no byte lost or duplicated; a_ready held low 20 cycles -> a_valid and fields stable throughout.
REQ-027 With the macro defined and TimeoutCycles = 16: 01 00 followed by an 16-cycle gap -> frame dropped, no TL traffic, busy_o = 0; a following full read completes.
REQ-028 rst_i asserted during RSP, then the device returns d_valid -> response drained, no tx byte, next frame correct.
